lcd_cmd_sched: RTL and testbench
================================

LCD_CMD_SCHED -- requirements
Module: lcd_cmd_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving per-requester command FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter BUSY_TO, default 4, giving the maximum cycles to wait for lcd_busy to rise after an issue.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; 0 = reset.
REQ-005 req0_valid  in  1  requester 0 presents a command.
REQ-006 req0_cmd  in  4  requester 0 command code (LCD command encoding).
REQ-007 req0_ready  out  1  requester 0 FIFO not full.
REQ-008 req1_valid  in  1  requester 1 presents a command.
REQ-009 req1_cmd  in  4  requester 1 command code.
REQ-010 req1_ready  out  1  requester 1 FIFO not full.
REQ-011 lcd_cmd  out  4  command to the LCD engine.
REQ-012 lcd_cmd_valid  out  1  command strobe to the LCD engine.
REQ-013 lcd_busy  in  1  LCD engine busy; commands are accepted only while 0.
REQ-014 lcd_done  in  1  LCD engine write-out complete pulse.
REQ-015 grant_id  out  1  requester owning the in-flight command.
REQ-016 cmd_done  out  1  one-cycle pulse on completion of the in-flight command.
REQ-017 wr_done  out  1  one-cycle pulse when a write command completes write-out.
REQ-018 err  out  1  sticky flag for busy-rise timeout.
REQ-019 idle  out  1  1 when the FSM is in S_IDLE and both FIFOs are empty.

Function
REQ-020 Each requester SHALL own a DEPTH-entry FIFO; a push SHALL occur when valid & ready; ready SHALL equal not-full (registered count, no combinational path from valid).
REQ-021 A push and a pop on the same FIFO in the same cycle SHALL both take effect, leaving the count unchanged; a push while full SHALL NOT be possible.
REQ-022 FSM states SHALL be S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_IDLE.
REQ-023 S_IDLE -> S_ISSUE when lcd_busy==0 and at least one FIFO is non-empty; on that edge the scheduler SHALL pop the granted head into a command register and update grant_id.
REQ-024 Arbitration SHALL be round-robin: a priority pointer (reset 0) selects the preferred requester when both are non-empty; after every grant the pointer SHALL point to the non-granted requester; a sole non-empty FIFO SHALL be granted regardless of the pointer.
REQ-025 In S_ISSUE, lcd_cmd_valid SHALL be 1 for exactly one cycle with lcd_cmd = the popped command; the next state SHALL be S_WAIT_BUSY.
REQ-026 In S_WAIT_BUSY: if lcd_busy==1, go to S_WAIT_IDLE; if BUSY_TO cycles elapse without lcd_busy, set err, pulse cmd_done and return to S_IDLE.
REQ-027 In S_WAIT_IDLE: when lcd_busy==0, pulse cmd_done for one cycle and return to S_IDLE; the next issue SHALL occur no earlier than the following cycle.
REQ-028 lcd_cmd_valid SHALL be 0 in every state except S_ISSUE; lcd_cmd SHALL hold its last value otherwise.
REQ-029 A command code 0 or 12..15 SHALL be classified as a write; in S_WAIT_IDLE with a write in flight, lcd_done==1 SHALL produce a one-cycle wr_done pulse; lcd_done at any other time SHALL be ignored.
REQ-030 lcd_busy==1 in S_IDLE SHALL stall issue indefinitely while FIFOs continue to accept pushes.
REQ-031 err SHALL clear only on reset.
REQ-032 Issue order within one requester SHALL be FIFO order; no command SHALL be dropped or duplicated.

Reset
REQ-033 While reset==0: FSM = S_IDLE; FIFOs empty; pointer = 0; lcd_cmd = 0; lcd_cmd_valid, grant_id, cmd_done, wr_done and err = 0; req0_ready and req1_ready = 1; idle = 1.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight and queued commands, with no cmd_done or wr_done pulse.

Verification
REQ-035 Hold lcd_busy=1 for 66 cycles and push cmd 1 on req0 -> no lcd_cmd_valid until lcd_busy falls, then one pulse with lcd_cmd=1 and grant_id=0.
REQ-036 Preload req0={1,2} and req1={3,4} with lcd_busy=0 -> issue order 1,3,2,4 with grant_id 0,1,0,1.
REQ-037 Push 5 commands on req0 while lcd_busy=1 -> req0_ready=0 after the 4th push; the 5th is not accepted; 4 issues follow.
REQ-038 Issue cmd 5 with lcd_busy held 0 -> err=1 after 4 cycles, cmd_done pulses, FSM returns to S_IDLE and the next command issues.
REQ-039 Issue cmd 0, model busy for 65 cycles, then lcd_done -> wr_done pulses once, then cmd_done when busy falls.
REQ-040 Assert reset in S_WAIT_IDLE with 3 queued entries -> all outputs at reset values, idle=1, no pulses.

Source files
------------

// File: rtl/lcd_cmd_sched.sv
// Two-requester round-robin command scheduler in front of an LCD engine.
// Each requester owns a small FIFO; exactly one command is in flight at a time.

module lcd_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [3:0] din,
    input  logic       pop,
    output logic [3:0] head,
    output logic       not_empty,
    output logic       not_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);
    assign not_full  = (count != FULL_CNT);
endmodule

module lcd_cmd_sched #(
    parameter int DEPTH   = 4,
    parameter int BUSY_TO = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_cmd,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_cmd,
    output logic       req1_ready,
    output logic [3:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic       grant_id,
    output logic       cmd_done,
    output logic       wr_done,
    output logic       err,
    output logic       idle
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_IDLE} state_t;

    localparam int TW = $clog2(BUSY_TO + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

    state_t        state;
    logic          prio;
    logic          wr_flight;
    logic          wr_seen;
    logic [TW-1:0] timer;

    logic       ne0, ne1;
    logic [3:0] head0, head1;
    logic       push0, push1, pop0, pop1;
    logic       issue, sel;
    logic [3:0] issue_cmd;

    function automatic logic is_write(input logic [3:0] code);
        return (code == 4'd0) || (code >= 4'd12);
    endfunction

    assign push0 = req0_valid & req0_ready;
    assign push1 = req1_valid & req1_ready;

    lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .push(push0), .din(req0_cmd), .pop(pop0),
        .head(head0), .not_empty(ne0), .not_full(req0_ready)
    );

    lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .push(push1), .din(req1_cmd), .pop(pop1),
        .head(head1), .not_empty(ne1), .not_full(req1_ready)
    );

    // The pointer only matters when both heads compete; a lone requester always wins.
    assign issue     = (state == S_IDLE) && !lcd_busy && (ne0 || ne1);
    assign sel       = (ne0 && ne1) ? prio : !ne0;
    assign pop0      = issue && !sel;
    assign pop1      = issue && sel;
    assign issue_cmd = sel ? head1 : head0;
    assign idle      = (state == S_IDLE) && !ne0 && !ne1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            prio          <= 1'b0;
            lcd_cmd       <= '0;
            lcd_cmd_valid <= 1'b0;
            grant_id      <= 1'b0;
            cmd_done      <= 1'b0;
            wr_done       <= 1'b0;
            err           <= 1'b0;
            timer         <= '0;
            wr_flight     <= 1'b0;
            wr_seen       <= 1'b0;
        end else begin
            lcd_cmd_valid <= 1'b0;
            cmd_done      <= 1'b0;
            wr_done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        lcd_cmd       <= issue_cmd;
                        lcd_cmd_valid <= 1'b1;
                        grant_id      <= sel;
                        prio          <= !sel;
                        wr_flight     <= is_write(issue_cmd);
                        wr_seen       <= 1'b0;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (lcd_busy) begin
                        state <= S_WAIT_IDLE;
                    end else if (timer == TO_LAST) begin
                        err      <= 1'b1;
                        cmd_done <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    // Only the first write-out completion of a write command is reported.
                    if (lcd_done && wr_flight && !wr_seen) begin
                        wr_done <= 1'b1;
                        wr_seen <= 1'b1;
                    end
                    if (!lcd_busy) begin
                        cmd_done <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Bench for lcd_cmd_sched: cycle table, directed corner sequences and a
// randomized run scored against a queue-level model of the scheduler.

module tb_lcd_cmd_sched;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_cmd, req1_cmd;
    logic       req0_ready, req1_ready;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy, lcd_done;
    logic       grant_id, cmd_done, wr_done, err, idle;

    int n_chk  = 0;
    int n_pass = 0;

    lcd_cmd_sched #(.DEPTH(DEPTH), .BUSY_TO(4)) dut (
        .clk(clk), .reset(reset_n),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
        .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done),
        .grant_id(grant_id), .cmd_done(cmd_done), .wr_done(wr_done),
        .err(err), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit       v0;
        bit [3:0] c0;
        bit       v1;
        bit [3:0] c1;
        bit       busy;
        bit       r0;
        bit       r1;
        bit       vld;
        bit [3:0] cmd;
        bit       gid;
        bit       cd;
        bit       idl;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b0; req0_cmd = '0;
        req1_valid = 1'b0; req1_cmd = '0;
        lcd_busy   = 1'b0; lcd_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".lcd_cmd"}, lcd_cmd, 0);
        chk({tag, ".valid"}, lcd_cmd_valid, 0);
        chk({tag, ".grant"}, grant_id, 0);
        chk({tag, ".cmd_done"}, cmd_done, 0);
        chk({tag, ".wr_done"}, wr_done, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".ready0"}, req0_ready, 1);
        chk({tag, ".ready1"}, req1_ready, 1);
        chk({tag, ".idle"}, idle, 1);
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (lcd_cmd_valid) got = 1'b1;
        end
    endtask

    // Engine responder: busy for `hold` cycles (optional lcd_done near the end), then wait for cmd_done.
    task automatic serve(input int hold, input bit pulse, output int wr_cnt, output int cd_cnt);
        wr_cnt   = 0;
        cd_cnt   = 0;
        lcd_busy = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            wr_cnt  += int'(wr_done);
            cd_cnt  += int'(cmd_done);
            lcd_done = pulse && (i == hold - 2);
        end
        lcd_done = 1'b0;
        lcd_busy = 1'b0;
        for (int i = 0; i < 6 && cd_cnt == 0; i++) begin
            step();
            wr_cnt += int'(wr_done);
            cd_cnt += int'(cmd_done);
        end
    endtask

    task automatic run_random(input int ncyc);
        int q0[$];
        int q1[$];
        bit rr, in_fl, to_mode, pdone, cur_wr, exp_err, acc0, acc1;
        int k, d, len, g, e;
        int pushes, issues, dones, exp_wr, got_wr;
        int n_rdy, n_spur, n_overlap, n_spur_cd;
        rr = 0; in_fl = 0; to_mode = 0; pdone = 0; cur_wr = 0; exp_err = 0;
        k = 0; d = 1; len = 2; pushes = 0; issues = 0; dones = 0; exp_wr = 0; got_wr = 0;
        n_rdy = 0; n_spur = 0; n_overlap = 0; n_spur_cd = 0;
        for (int cyc = 0; cyc < ncyc + 600; cyc++) begin
            if (cyc >= ncyc && q0.size() == 0 && q1.size() == 0 && !in_fl) break;
            if (cyc < ncyc) begin
                req0_valid = ($urandom_range(0, 99) < 35);
                req0_cmd   = 4'($urandom_range(0, 15));
                req1_valid = ($urandom_range(0, 99) < 35);
                req1_cmd   = 4'($urandom_range(0, 15));
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            acc0 = req0_valid && (q0.size() < DEPTH);
            acc1 = req1_valid && (q1.size() < DEPTH);
            step();
            if (lcd_cmd_valid) begin
                issues++;
                if (in_fl) n_overlap++;
                if (q0.size() == 0 && q1.size() == 0) begin
                    n_spur++;
                end else begin
                    g  = (q0.size() > 0 && q1.size() > 0) ? int'(rr) : ((q0.size() > 0) ? 0 : 1);
                    e  = (g == 0) ? q0.pop_front() : q1.pop_front();
                    rr = (g == 0);
                    chk($sformatf("rand_cmd#%0d", issues), lcd_cmd, e);
                    chk($sformatf("rand_grant#%0d", issues), grant_id, g);
                    cur_wr = (e == 0) || (e >= 12);
                end
                in_fl   = 1'b1;
                k       = 0;
                to_mode = ($urandom_range(0, 99) < 4);
                d       = $urandom_range(1, 2);
                len     = $urandom_range(2, 5);
                pdone   = 1'($urandom_range(0, 1));
                if (to_mode) exp_err = 1'b1;
                if (!to_mode && pdone && cur_wr) exp_wr++;
            end else if (in_fl) begin
                k++;
            end
            if (acc0) begin q0.push_back(int'(req0_cmd)); pushes++; end
            if (acc1) begin q1.push_back(int'(req1_cmd)); pushes++; end
            if (req0_ready !== (q0.size() < DEPTH)) n_rdy++;
            if (req1_ready !== (q1.size() < DEPTH)) n_rdy++;
            if (cmd_done) begin
                if (!in_fl) n_spur_cd++;
                in_fl = 1'b0;
                dones++;
            end
            got_wr += int'(wr_done);
            if (in_fl && !to_mode) begin
                lcd_busy = (k >= d) && (k < d + len);
                lcd_done = pdone && (k == d + 1);
            end else if (in_fl) begin
                lcd_busy = 1'b0;
                lcd_done = 1'b0;
            end else begin
                lcd_busy = ($urandom_range(0, 99) < 20);
                lcd_done = ($urandom_range(0, 99) < 10);
            end
        end
        chk("rand_drained", q0.size() + q1.size() + int'(in_fl), 0);
        chk("rand_issue_count", issues, pushes);
        chk("rand_done_count", dones, issues);
        chk("rand_wr_done_count", got_wr, exp_wr);
        chk("rand_err", err, exp_err);
        chk("rand_ready_mismatches", n_rdy, 0);
        chk("rand_spurious_issue", n_spur, 0);
        chk("rand_overlap", n_overlap, 0);
        chk("rand_spurious_cmd_done", n_spur_cd, 0);
        lcd_busy = 1'b0;
        lcd_done = 1'b0;
        step();
        chk("rand_idle_end", idle, 1);
    endtask

    initial begin
        bit got;
        bit seen;
        int wr, cd, issued, n, mism;
        bit err_early;
        int seq0[$];
        int exp_cmd [4];
        int exp_gid [4];

        // cycle table: fill both FIFOs while the engine stalls, then release
        tbl[0]  = '{1'b1, 4'd1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'd2, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'd3, 1'b1, 4'd9,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'd4, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'd5, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'd0, 1'b1, 4'd10, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'd0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'd0, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0};

        do_reset();
        check_reset_outputs("reset");

        for (int i = 0; i < 14; i++) begin
            req0_valid = tbl[i].v0; req0_cmd = tbl[i].c0;
            req1_valid = tbl[i].v1; req1_cmd = tbl[i].c1;
            lcd_busy   = tbl[i].busy;
            step();
            chk($sformatf("vec%0d.ready0", i), req0_ready, tbl[i].r0);
            chk($sformatf("vec%0d.ready1", i), req1_ready, tbl[i].r1);
            chk($sformatf("vec%0d.valid", i), lcd_cmd_valid, tbl[i].vld);
            chk($sformatf("vec%0d.cmd", i), lcd_cmd, tbl[i].cmd);
            chk($sformatf("vec%0d.grant", i), grant_id, tbl[i].gid);
            chk($sformatf("vec%0d.cmd_done", i), cmd_done, tbl[i].cd);
            chk($sformatf("vec%0d.idle", i), idle, tbl[i].idl);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // finish the fill scenario: req0 must issue 1,2,3,4 and never the rejected 5
        seq0.push_back(1);
        issued = 2;
        for (int j = 0; j < 10; j++) begin
            serve(2, 1'b0, wr, cd);
            wait_valid(6, got);
            if (!got) break;
            issued++;
            if (grant_id == 1'b0) seq0.push_back(int'(lcd_cmd));
        end
        chk("fill_issue_count", issued, 8);
        chk("fill_req0_count", seq0.size(), 4);
        mism = 0;
        for (int j = 0; j < seq0.size(); j++) if (seq0[j] != j + 1) mism++;
        chk("fill_req0_order", mism, 0);

        // long stall while busy is held high
        do_reset();
        lcd_busy = 1'b1;
        req0_valid = 1'b1; req0_cmd = 4'd1;
        step();
        req0_valid = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 65; j++) begin
            step();
            if (lcd_cmd_valid) seen = 1'b1;
        end
        chk("stall_no_valid", seen, 0);
        lcd_busy = 1'b0;
        wait_valid(3, got);
        chk("stall_release_valid", got, 1);
        chk("stall_release_cmd", lcd_cmd, 1);
        chk("stall_release_grant", grant_id, 0);

        // round-robin between two preloaded queues
        do_reset();
        lcd_busy = 1'b1;
        req0_valid = 1'b1; req0_cmd = 4'd1; req1_valid = 1'b1; req1_cmd = 4'd3;
        step();
        req0_cmd = 4'd2; req1_cmd = 4'd4;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0; lcd_busy = 1'b0;
        exp_cmd = '{1, 3, 2, 4};
        exp_gid = '{0, 1, 0, 1};
        for (int j = 0; j < 4; j++) begin
            wait_valid(6, got);
            chk($sformatf("rr%0d.valid", j), got, 1);
            chk($sformatf("rr%0d.cmd", j), lcd_cmd, exp_cmd[j]);
            chk($sformatf("rr%0d.grant", j), grant_id, exp_gid[j]);
            serve(3, 1'b1, wr, cd);
            chk($sformatf("rr%0d.no_wr_done", j), wr, 0);
            chk($sformatf("rr%0d.cmd_done", j), cd, 1);
        end
        step();
        chk("rr_idle_after", idle, 1);

        // busy never rises: timeout, sticky err, next command still issues
        do_reset();
        req0_valid = 1'b1; req0_cmd = 4'd5;
        step();
        req0_cmd = 4'd6;
        step();
        req0_valid = 1'b0;
        chk("to_issue_valid", lcd_cmd_valid, 1);
        chk("to_issue_cmd", lcd_cmd, 5);
        n = 0; cd = 0; err_early = 1'b0;
        for (int j = 0; j < 10 && cd == 0; j++) begin
            step();
            n++;
            if (!cmd_done && err) err_early = 1'b1;
            cd = int'(cmd_done);
        end
        chk("to_cmd_done", cd, 1);
        chk("to_latency", n, 5);
        chk("to_err_set", err, 1);
        chk("to_err_early", err_early, 0);
        wait_valid(4, got);
        chk("to_next_valid", got, 1);
        chk("to_next_cmd", lcd_cmd, 6);
        serve(3, 1'b0, wr, cd);
        chk("to_next_done", cd, 1);
        chk("to_err_sticky", err, 1);

        // write command with long busy and a write-out completion
        do_reset();
        req0_valid = 1'b1; req0_cmd = 4'd0;
        step();
        req0_valid = 1'b0;
        wait_valid(4, got);
        chk("wr_valid", got, 1);
        chk("wr_cmd", lcd_cmd, 0);
        serve(65, 1'b1, wr, cd);
        chk("wr_done_once", wr, 1);
        chk("wr_cmd_done", cd, 1);
        chk("wr_no_err", err, 0);

        // reset while a command is in flight and three are queued
        do_reset();
        lcd_busy = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            req0_valid = 1'b1; req0_cmd = 4'(j);
            step();
        end
        req0_valid = 1'b0; lcd_busy = 1'b0;
        wait_valid(4, got);
        chk("rst_mid_issue", got, 1);
        lcd_busy = 1'b1;
        step();
        step();
        chk("rst_mid_busy_state", idle, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        seen = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            if (cmd_done || wr_done || lcd_cmd_valid) seen = 1'b1;
        end
        chk("rst_mid_no_pulse", seen, 0);
        reset_n = 1'b1;
        lcd_busy = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            if (lcd_cmd_valid) seen = 1'b1;
        end
        chk("rst_mid_queue_flushed", seen, 0);
        chk("rst_mid_idle", idle, 1);

        do_reset();
        run_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
